// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC test-pattern checker: default pattern word,
// alignment state encoding and a 32-bit population count.
package ttc_pkg;

  localparam logic [31:0] TTC_PATTERN = 32'hA18D9534;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ttc_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ttc_pattern_checker.sv
// Bit-serial TTC pattern receiver: hunts for word alignment, confirms it over
// several words, then accumulates received bits and bit errors while locked.
module ttc_pattern_checker
  import ttc_pkg::*;
#(
  parameter logic [31:0] PATTERN    = TTC_PATTERN,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_TOL    = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr,
  output logic             locked,
  output logic             word_tick,
  output logic [5:0]       word_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  localparam logic [5:0]     ERR_TOL_W    = 6'(ERR_TOL);
  localparam logic [3:0]     LOCK_CNT_W   = 4'(LOCK_CNT);
  localparam logic [3:0]     UNLOCK_CNT_W = 4'(UNLOCK_CNT);
  localparam logic [CNT_W:0] WORD_BITS    = (CNT_W+1)'(32);

  ttc_state_e       state_q, state_d;
  logic [31:0]      sr_q, sr_d;
  logic [4:0]       bitpos_q, bitpos_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             word_tick_q, word_tick_d;
  logic [5:0]       word_err_q, word_err_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;

  logic [31:0]      sr_next;
  logic [5:0]       errs;
  logic             err_ok;
  logic             boundary;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;
  logic [CNT_W:0]   bit_sum;
  logic [CNT_W:0]   err_sum;

  always_comb begin
    sr_next   = {in_bit, sr_q[31:1]};
    errs      = popcount32(sr_next ^ PATTERN);
    err_ok    = (errs <= ERR_TOL_W);
    boundary  = (bitpos_q == 5'd31);
    match_inc = match_cnt_q + 4'd1;
    miss_inc  = miss_cnt_q + 4'd1;
    // One extra bit on the sums catches overflow so the counters can stick at all-ones.
    bit_sum   = {1'b0, bit_cnt_q} + WORD_BITS;
    err_sum   = {1'b0, bit_err_cnt_q} + {{(CNT_W-5){1'b0}}, errs};

    state_d       = state_q;
    sr_d          = sr_q;
    bitpos_d      = bitpos_q;
    match_cnt_d   = match_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    word_tick_d   = 1'b0;
    word_err_d    = word_err_q;
    bit_cnt_d     = bit_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;

    if (in_valid) begin
      sr_d     = sr_next;
      bitpos_d = bitpos_q + 5'd1;
      case (state_q)
        HUNT: begin
          if (errs == 6'd0) begin
            bitpos_d    = 5'd0;
            match_cnt_d = 4'd1;
            state_d     = (LOCK_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (boundary) begin
            word_tick_d = 1'b1;
            word_err_d  = errs;
            if (err_ok) begin
              match_cnt_d = match_inc;
              if (match_inc >= LOCK_CNT_W) state_d = LOCK;
            end else begin
              match_cnt_d = 4'd0;
              state_d     = HUNT;
            end
          end
        end
        LOCK: begin
          if (boundary) begin
            word_tick_d   = 1'b1;
            word_err_d    = errs;
            bit_cnt_d     = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            bit_err_cnt_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
            if (err_ok) begin
              miss_cnt_d = 4'd0;
            end else if (miss_inc >= UNLOCK_CNT_W) begin
              miss_cnt_d  = 4'd0;
              match_cnt_d = 4'd0;
              state_d     = HUNT;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clearing overrides a coinciding word's contribution; alignment is untouched.
    if (clr) begin
      word_err_d    = 6'd0;
      bit_cnt_d     = '0;
      bit_err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      bitpos_q      <= '0;
      match_cnt_q   <= '0;
      miss_cnt_q    <= '0;
      word_tick_q   <= 1'b0;
      word_err_q    <= '0;
      bit_cnt_q     <= '0;
      bit_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bitpos_q      <= bitpos_d;
      match_cnt_q   <= match_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      word_tick_q   <= word_tick_d;
      word_err_q    <= word_err_d;
      bit_cnt_q     <= bit_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
    end
  end

  assign locked      = (state_q == LOCK);
  assign word_tick   = word_tick_q;
  assign word_err    = word_err_q;
  assign bit_cnt     = bit_cnt_q;
  assign bit_err_cnt = bit_err_cnt_q;

endmodule

// File: tb/tb_ttc_pattern_checker.sv
// Self-checking bench for ttc_pattern_checker: a default-width and an 8-bit
// counter instance share the stimulus and are compared against a word-level model.
module tb_ttc_pattern_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic clr = 1'b0;

  logic        locked_a, tick_a;
  logic [5:0]  werr_a;
  logic [31:0] bc_a, bec_a;
  logic        locked_b, tick_b;
  logic [5:0]  werr_b;
  logic [7:0]  bc_b, bec_b;

  ttc_pattern_checker dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .locked(locked_a), .word_tick(tick_a), .word_err(werr_a),
    .bit_cnt(bc_a), .bit_err_cnt(bec_a)
  );

  ttc_pattern_checker #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .locked(locked_b), .word_tick(tick_b), .word_err(werr_b),
    .bit_cnt(bc_b), .bit_err_cnt(bec_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] pat_v = 32'hA18D9534;
  int        ph = 0;
  bit [31:0] flip_mask = '0;

  // Reference model: last 32 received bits, bits since the alignment anchor,
  // and plain counts of good/bad words.
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCK = 2;
  bit     hist[$];
  int     m_mode, m_since, m_good, m_miss, m_werr;
  bit     m_tick;
  longint m_bits, m_errs;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (32) hist.push_back(1'b0);
    m_mode = M_HUNT; m_since = 0; m_good = 0; m_miss = 0; m_werr = 0;
    m_tick = 0; m_bits = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    int e;
    m_tick = 0;
    if (v) begin
      hist.push_back(b);
      void'(hist.pop_front());
      e = 0;
      for (int i = 0; i < 32; i++) if (hist[i] != pat_v[i]) e++;
      m_since++;
      if (m_mode == M_HUNT) begin
        if (e == 0) begin
          m_since = 0; m_good = 1; m_mode = M_VERIFY;
        end
      end else if (m_since == 32) begin
        m_since = 0; m_tick = 1; m_werr = e;
        if (m_mode == M_VERIFY) begin
          if (e <= 3) begin
            m_good++;
            if (m_good == 3) m_mode = M_LOCK;
          end else begin
            m_mode = M_HUNT; m_good = 0;
          end
        end else begin
          m_bits += 32; m_errs += e;
          if (e > 3) m_miss++; else m_miss = 0;
          if (m_miss == 4) begin
            m_mode = M_HUNT; m_miss = 0; m_good = 0;
          end
        end
      end
    end
    if (c) begin
      m_werr = 0; m_bits = 0; m_errs = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("locked", locked_a, 64'(m_mode == M_LOCK));
    chk("word_tick", tick_a, 64'(m_tick));
    chk("word_err", werr_a, 64'(m_werr));
    chk("bit_cnt", bc_a, sat(m_bits, 32));
    chk("bit_err_cnt", bec_a, sat(m_errs, 32));
    chk("locked8", locked_b, 64'(m_mode == M_LOCK));
    chk("word_tick8", tick_b, 64'(m_tick));
    chk("word_err8", werr_b, 64'(m_werr));
    chk("bit_cnt8", bc_b, sat(m_bits, 8));
    chk("bit_err_cnt8", bec_b, sat(m_errs, 8));
  endtask

  task automatic step(input bit b, input bit v, input bit c);
    in_bit = b; in_valid = v; clr = c;
    @(posedge clk);
    #1;
    model_step(b, v, c);
    check_all();
  endtask

  // Next generator bit (with the current word's flip mask) on valid cycles.
  task automatic send_pat(input bit v, input bit c);
    bit b;
    if (v) begin
      b  = pat_v[ph] ^ flip_mask[ph];
      ph = (ph + 1) % 32;
      if (ph == 0) flip_mask = '0;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    step(b, v, c);
  endtask

  task automatic send_words(input int n);
    repeat (32 * n) send_pat(1'b1, 1'b0);
  endtask

  function automatic bit [31:0] make_mask(input int n);
    bit [31:0] m;
    int cnt, p;
    m = '0; cnt = 0;
    while (cnt < n) begin
      p = $urandom_range(0, 31);
      if (!m[p]) begin
        m[p] = 1'b1; cnt++;
      end
    end
    return m;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_locked", locked_a, 0);
    chk("rst_word_err", werr_a, 0);
    chk("rst_bit_cnt", bc_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    int bitn;
    bit clr;
    bit locked;
    bit tick;
    int bc;
    int bec;
  } vec_t;

  vec_t tbl[9];
  int   lv_tab[9] = '{0, 0, 0, 1, 2, 3, 4, 5, 9};

  initial begin
    int sent, total, lock_at, vc, lock_vc, cnt;
    bit v;

    model_reset();
    #3;
    do_reset();

    // Clean aligned stream, checkpoints in bit numbers (1-based).
    tbl[0] = '{32,  0, 0, 0, 0,  0};
    tbl[1] = '{64,  0, 0, 1, 0,  0};
    tbl[2] = '{95,  0, 0, 0, 0,  0};
    tbl[3] = '{96,  0, 1, 1, 0,  0};
    tbl[4] = '{97,  0, 1, 0, 0,  0};
    tbl[5] = '{128, 0, 1, 1, 32, 0};
    tbl[6] = '{160, 0, 1, 1, 64, 0};
    tbl[7] = '{192, 1, 1, 1, 0,  0};
    tbl[8] = '{224, 0, 1, 1, 32, 0};
    ph = 0; sent = 0;
    for (int k = 0; k < 9; k++) begin
      while (sent < tbl[k].bitn) begin
        send_pat(1'b1, (sent + 1 == tbl[k].bitn) ? tbl[k].clr : 1'b0);
        sent++;
      end
      chk("t1_locked", locked_a, 64'(tbl[k].locked));
      chk("t1_tick", tick_a, 64'(tbl[k].tick));
      chk("t1_bit_cnt", bc_a, 64'(tbl[k].bc));
      chk("t1_bit_err_cnt", bec_a, 64'(tbl[k].bec));
    end

    // 13 random leading bits, then the pattern.
    do_reset();
    ph = 0;
    repeat (13) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    total = 13; lock_at = 0;
    for (int i = 0; i < 300 && lock_at == 0; i++) begin
      send_pat(1'b1, 1'b0);
      total++;
      if (locked_a) lock_at = total;
    end
    chk("t2_lock_bit", lock_at, 109);
    chk("t2_word_err", werr_a, 0);

    // Locked: 2 flips in one word, then 4 words of 5 flips.
    while (ph != 0) send_pat(1'b1, 1'b0);
    send_words(1);
    flip_mask = make_mask(2);
    send_words(1);
    chk("t3_word_err", werr_a, 2);
    chk("t3_bit_err_cnt", bec_a, 2);
    chk("t3_locked", locked_a, 1);
    for (int w = 0; w < 4; w++) begin
      flip_mask = make_mask(5);
      send_words(1);
      if (w < 3) chk("t3_still_locked", locked_a, 1);
    end
    chk("t3_unlocked", locked_a, 0);
    chk("t3_bit_err_cnt22", bec_a, 22);
    chk("t3_bit_cnt", bc_a, 192);

    // 50% in_valid duty over the clean stream.
    do_reset();
    ph = 0; vc = 0; lock_vc = 0; cnt = 0;
    while (vc < 128 && cnt < 2000) begin
      v = 1'($urandom_range(0, 1));
      send_pat(v, 1'b0);
      if (v) vc++;
      cnt++;
      if (locked_a && lock_vc == 0) lock_vc = vc;
    end
    chk("t4_budget", vc, 128);
    chk("t4_lock_valid_bits", lock_vc, 96);
    chk("t4_bit_cnt", bc_a, 32);
    chk("t4_bit_err_cnt", bec_a, 0);

    // Saturation of the 8-bit instance and clr on a boundary.
    do_reset();
    ph = 0;
    send_words(3);
    chk("t5_locked", locked_b, 1);
    send_words(9);
    chk("t5_sat8", bc_b, 255);
    chk("t5_bit_cnt32", bc_a, 288);
    repeat (31) send_pat(1'b1, 1'b0);
    send_pat(1'b1, 1'b1);
    chk("t5_clr_bc8", bc_b, 0);
    chk("t5_clr_bc32", bc_a, 0);
    chk("t5_clr_locked", locked_b, 1);
    chk("t5_clr_tick", tick_b, 1);
    send_words(1);
    chk("t5_after_clr", bc_b, 32);

    // Reset during VERIFY, then relock on the continuing stream.
    do_reset();
    ph = 0;
    send_words(2);
    chk("t6_tick_pre", tick_a, 1);
    do_reset();
    chk("t6_rst_tick", tick_a, 0);
    cnt = 0;
    while (!locked_a && cnt < 400) begin
      send_pat(1'b1, 1'b0);
      cnt++;
    end
    chk("t6_relock_bits", cnt, 96);

    // Randomized run against the model: light errors, then heavy errors.
    do_reset();
    ph = 0;
    repeat (7) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (ph == 0) begin
        if (i < 2000) flip_mask = make_mask(lv_tab[$urandom_range(0, 8)]);
        else          flip_mask = make_mask($urandom_range(0, 9));
      end
      send_pat($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
